// File: rtl/ibex_fpu_wb.sv
// rtl/ibex_fpu_wb.sv - FPU writeback stage: short/long op latency, regfile write pulse, fflags accrual
// Define IBEX_FPU_FFLAGS_EN to build the fflags register, flag mapping and CSR write path.
module ibex_fpu_wb #(
  parameter int unsigned DIV_SQRT_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic        issue_long_i,
  input  logic        issue_to_int_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [31:0] fpu_wdata_i,
  input  logic [7:0]  fpu_status_i,
  input  logic        flush_i,
  output logic        fp_we_o,
  output logic [4:0]  fp_waddr_o,
  output logic [31:0] fp_wdata_o,
  output logic        int_we_o,
  output logic [4:0]  int_waddr_o,
  output logic [31:0] int_wdata_o,
  input  logic        csr_we_i,
  input  logic [4:0]  csr_wdata_i,
  output logic [4:0]  fflags_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(DIV_SQRT_LAT - 1);

  state_e      state;
  state_e      state_next;
  logic [3:0]  cnt;
  logic [4:0]  rd_q;
  logic        to_int_q;
  logic        wb_to_int;
  logic        accept;
  logic        capture_short;
  logic        capture_long;
  logic        capture;
  logic [4:0]  cap_rd;
  logic        cap_to_int;

  assign accept        = issue_valid_i & issue_ready_o & ~flush_i;
  assign capture_short = accept & ~issue_long_i;
  assign capture_long  = (state == S_WAIT) & (cnt == 4'd0) & ~flush_i;
  assign capture       = capture_short | capture_long;
  // A long op's destination was latched at issue; the issue bus may carry anything now.
  assign cap_rd        = capture_long ? rd_q : issue_rd_i;
  assign cap_to_int    = capture_long ? to_int_q : issue_to_int_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = issue_long_i ? S_WAIT : S_WB;
      end
      S_WAIT: begin
        if (flush_i)              state_next = S_IDLE;
        else if (cnt == 4'd0)     state_next = S_WB;
      end
      S_WB: begin
        if (accept)               state_next = issue_long_i ? S_WAIT : S_WB;
        else                      state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    issue_ready_o = 1'b0;
    busy_o        = 1'b1;
    fp_we_o       = 1'b0;
    int_we_o      = 1'b0;
    case (state)
      S_IDLE: begin
        issue_ready_o = 1'b1;
        busy_o        = 1'b0;
      end
      S_WB: begin
        issue_ready_o = 1'b1;
        fp_we_o       = ~wb_to_int & ~flush_i;
        int_we_o      = wb_to_int & ~flush_i;
      end
      default: begin
        issue_ready_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt         <= 4'd0;
      rd_q        <= 5'd0;
      to_int_q    <= 1'b0;
      wb_to_int   <= 1'b0;
      fp_waddr_o  <= 5'd0;
      fp_wdata_o  <= 32'd0;
      int_waddr_o <= 5'd0;
      int_wdata_o <= 32'd0;
    end else begin
      if (accept & issue_long_i) begin
        cnt      <= CNT_LOAD;
        rd_q     <= issue_rd_i;
        to_int_q <= issue_to_int_i;
      end else if (state == S_WAIT) begin
        if (flush_i)          cnt <= 4'd0;
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
      // Each port keeps its own copy so an idle port never shows the other file's traffic.
      if (capture) begin
        wb_to_int <= cap_to_int;
        if (cap_to_int) begin
          int_waddr_o <= cap_rd;
          int_wdata_o <= fpu_wdata_i;
        end else begin
          fp_waddr_o  <= cap_rd;
          fp_wdata_o  <= fpu_wdata_i;
        end
      end
    end
  end

`ifdef IBEX_FPU_FFLAGS_EN
  logic [4:0] flags_q;
  logic [4:0] fflags;
  logic [4:0] fflags_next;
  logic [4:0] cap_flags;
  logic       unused_status;

  assign cap_flags = {fpu_status_i[2], fpu_status_i[7], fpu_status_i[4],
                      fpu_status_i[3] & fpu_status_i[5], fpu_status_i[5] | fpu_status_i[4]};
  assign unused_status = ^{fpu_status_i[1:0], fpu_status_i[6]};

  always_comb begin
    fflags_next = csr_we_i ? csr_wdata_i : fflags;
    if ((state == S_WB) && !flush_i) fflags_next = fflags_next | flags_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q <= 5'd0;
      fflags  <= 5'd0;
    end else begin
      if (capture) flags_q <= cap_flags;
      fflags <= fflags_next;
    end
  end

  assign fflags_o = fflags;
`else
  logic unused_flags;
  assign unused_flags = ^{csr_we_i, csr_wdata_i, fpu_status_i};
  assign fflags_o     = 5'd0;
`endif

endmodule

// File: tb/tb_ibex_fpu_wb.sv
// tb/tb_ibex_fpu_wb.sv - randomized bench for ibex_fpu_wb against a timestamp-based transaction model
module tb_ibex_fpu_wb;
  localparam int LAT = 4;
`ifdef IBEX_FPU_FFLAGS_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic        issue_long = 1'b0;
  logic        issue_to_int = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [31:0] fpu_wdata = 32'd0;
  logic [7:0]  fpu_status = 8'd0;
  logic        flush = 1'b0;
  logic        fp_we;
  logic [4:0]  fp_waddr;
  logic [31:0] fp_wdata;
  logic        int_we;
  logic [4:0]  int_waddr;
  logic [31:0] int_wdata;
  logic        csr_we = 1'b0;
  logic [4:0]  csr_wdata = 5'd0;
  logic [4:0]  fflags;
  logic        busy;

  always #5 clk = ~clk;

  ibex_fpu_wb #(.DIV_SQRT_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_long_i(issue_long), .issue_to_int_i(issue_to_int), .issue_rd_i(issue_rd),
    .fpu_wdata_i(fpu_wdata), .fpu_status_i(fpu_status), .flush_i(flush),
    .fp_we_o(fp_we), .fp_waddr_o(fp_waddr), .fp_wdata_o(fp_wdata),
    .int_we_o(int_we), .int_waddr_o(int_waddr), .int_wdata_o(int_wdata),
    .csr_we_i(csr_we), .csr_wdata_i(csr_wdata), .fflags_o(fflags), .busy_o(busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit known = 1'b0;

  // Model: a write due this cycle, and a long op waiting for its capture timestamp.
  bit          wb_now = 1'b0;
  bit          wb_to_int = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic [4:0]  wb_flags = 5'd0;
  bit          lp = 1'b0;
  int          lp_cap = 0;
  logic [4:0]  lp_rd = 5'd0;
  bit          lp_to_int = 1'b0;
  logic [4:0]  m_fflags = 5'd0;

  bit          e_ready, e_busy, e_fp_we, e_int_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  logic [31:0] cur_d = 32'd0;
  logic [7:0]  cur_s = 8'd0;

  function automatic logic [4:0] map_flags(input logic [7:0] s);
    return {s[2], s[7], s[4], s[3] & s[5], s[5] | s[4]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit lg, input bit ti, input logic [4:0] rd,
                      input logic [31:0] d, input logic [7:0] s, input bit fl,
                      input bit cw, input logic [4:0] cd);
    bit          acc, nwb, n_to_int;
    logic [4:0]  n_rd, n_flags, base;
    logic [31:0] n_data;
    @(negedge clk);
    rst = r; issue_valid = v; issue_long = lg; issue_to_int = ti; issue_rd = rd;
    fpu_wdata = d; fpu_status = s; flush = fl; csr_we = cw; csr_wdata = cd;
    cur_d = d; cur_s = s;
    #1;
    e_ready  = !lp;
    e_busy   = lp || wb_now;
    e_fp_we  = wb_now && !wb_to_int && !fl;
    e_int_we = wb_now && wb_to_int && !fl;
    e_waddr  = wb_rd;
    e_wdata  = wb_data;
    if (known) begin
      chk("issue_ready", issue_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("fp_we", fp_we, e_fp_we);
      chk("int_we", int_we, e_int_we);
      chk("fflags", fflags, m_fflags);
      if (e_fp_we) begin
        chk("fp_waddr", fp_waddr, e_waddr);
        chk("fp_wdata", fp_wdata, e_wdata);
      end
      if (e_int_we) begin
        chk("int_waddr", int_waddr, e_waddr);
        chk("int_wdata", int_wdata, e_wdata);
      end
    end
    @(posedge clk);
    if (r) begin
      known = 1'b1; wb_now = 1'b0; lp = 1'b0; m_fflags = 5'd0;
    end else if (known) begin
      acc = v && !lp && !fl;
      nwb = 1'b0; n_to_int = 1'b0; n_rd = 5'd0; n_data = 32'd0; n_flags = 5'd0;
      if (lp && fl) begin
        lp = 1'b0;
      end else if (lp && cyc == lp_cap) begin
        nwb = 1'b1; n_to_int = lp_to_int; n_rd = lp_rd; n_data = d; n_flags = map_flags(s);
        lp = 1'b0;
      end
      if (acc) begin
        if (lg) begin
          lp = 1'b1; lp_cap = cyc + LAT; lp_rd = rd; lp_to_int = ti;
        end else begin
          nwb = 1'b1; n_to_int = ti; n_rd = rd; n_data = d; n_flags = map_flags(s);
        end
      end
      base = cw ? cd : m_fflags;
      if (wb_now && !fl) base = base | wb_flags;
      m_fflags = FF_EN ? base : 5'd0;
      wb_now = nwb;
      if (nwb) begin
        wb_to_int = n_to_int; wb_rd = n_rd; wb_data = n_data; wb_flags = n_flags;
      end
    end
    cyc++;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, cur_d, cur_s, 0, 0, 5'd0);
  endtask

  int ready_low, we_at, writes;

  initial begin
    step(1, 0, 0, 0, 5'd0, 32'd0, 8'd0, 0, 0, 5'd0);
    #2;
    chk("rst_fp_waddr", fp_waddr, 32'd0);
    chk("rst_fp_wdata", fp_wdata, 32'd0);
    chk("rst_int_waddr", int_waddr, 32'd0);
    chk("rst_int_wdata", int_wdata, 32'd0);
    step(1, 0, 0, 0, 5'd0, 32'd0, 8'd0, 0, 0, 5'd0);
    chk("pin_rst_ready", e_ready, 1);
    chk("pin_rst_busy", e_busy, 0);

    // Short FADD
    step(0, 1, 0, 0, 5'd5, 32'h3F800000, 8'h00, 0, 0, 5'd0);
    nop(1);
    chk("pin_fadd_we", e_fp_we, 1);
    chk("pin_fadd_addr", e_waddr, 5);
    chk("pin_fadd_data", e_wdata, 32'h3F800000);
    nop(1);
    chk("pin_fadd_we_off", e_fp_we, 0);
    chk("pin_fadd_fflags", m_fflags, 0);

    // Three back-to-back short ops
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 0, 5'(i), 32'h1000 + 32'(i), 8'h00, 0, 0, 5'd0);
      chk("pin_b2b_ready", e_ready, 1);
      if (i > 1) chk("pin_b2b_we", e_fp_we, 1);
    end
    nop(1);
    chk("pin_b2b_last_addr", e_waddr, 3);
    nop(1);

    // FDIV with DZ
    step(0, 1, 1, 0, 5'd7, 32'h40490FDB, 8'h80, 0, 0, 5'd0);
    ready_low = 0; we_at = 0;
    for (int i = 1; i <= 6; i++) begin
      nop(1);
      if (!e_ready) ready_low++;
      if (e_fp_we) we_at = i;
    end
    chk("pin_fdiv_ready_low", ready_low, 4);
    chk("pin_fdiv_we_cycle", we_at, 5);
    chk("pin_fdiv_fflags", m_fflags, FF_EN ? 5'b01000 : 5'd0);

    // FLOAT2INT with NV
    step(0, 0, 0, 0, 5'd0, 32'd0, 8'h00, 0, 1, 5'd0);
    step(0, 1, 0, 1, 5'd10, 32'hFFFFFFFF, 8'h04, 0, 0, 5'd0);
    nop(1);
    chk("pin_f2i_int_we", e_int_we, 1);
    chk("pin_f2i_fp_we", e_fp_we, 0);
    chk("pin_f2i_addr", e_waddr, 10);
    chk("pin_f2i_data", e_wdata, 32'hFFFFFFFF);
    chk("pin_f2i_fflags", m_fflags, FF_EN ? 5'b10000 : 5'd0);

    // Long op flushed on its second WAIT cycle
    step(0, 1, 1, 0, 5'd12, 32'h12345678, 8'h20, 0, 0, 5'd0);
    nop(1);
    step(0, 0, 0, 0, 5'd0, cur_d, cur_s, 1, 0, 5'd0);
    nop(1);
    chk("pin_flush_ready", e_ready, 1);
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      nop(1);
      if (e_fp_we || e_int_we) writes++;
    end
    chk("pin_flush_writes", writes, 0);
    chk("pin_flush_fflags", m_fflags, FF_EN ? 5'b10000 : 5'd0);

    // CSR write coinciding with a WB carrying invalid
    step(0, 1, 0, 0, 5'd3, 32'h7FC00000, 8'h04, 0, 0, 5'd0);
    step(0, 0, 0, 0, 5'd0, cur_d, cur_s, 0, 1, 5'b00001);
    chk("pin_csr_wb_fflags", m_fflags, FF_EN ? 5'b10001 : 5'd0);
    step(0, 0, 0, 0, 5'd0, cur_d, cur_s, 0, 1, 5'b00000);
    chk("pin_csr_clear", m_fflags, 0);

    // Reset in the middle of WAIT drops the op
    step(0, 1, 1, 1, 5'd9, 32'hCAFEF00D, 8'h30, 0, 0, 5'd0);
    nop(1);
    step(1, 0, 0, 0, 5'd0, cur_d, cur_s, 0, 0, 5'd0);
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      nop(1);
      if (e_fp_we || e_int_we) writes++;
    end
    chk("pin_rst_wait_writes", writes, 0);

    // Randomized traffic; operands held while a long op is outstanding
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      logic [7:0]  s;
      d = lp ? cur_d : $urandom;
      s = lp ? cur_s : 8'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, 5'($urandom), d, s, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ibex_fpu_wb.md
# ibex_fpu_wb

Writeback and exception-flag stage placed directly downstream of the combinational `ibex_FPU` datapath. It accepts one FP operation per handshake and samples the FPU result and DesignWare status after an op-class-dependent latency. Long ops (div/sqrt) get a configurable multicycle window. It then drives a single-cycle write pulse to the FP or integer register file and accrues RISC-V `fflags`, which are readable and writable through a CSR port.

## Interface
Parameters:
- `DIV_SQRT_LAT`, default 4: cycles the FPU inputs are held for div/sqrt before sampling. Legal range 1..15.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `issue_valid_i`, in, 1: upstream presents an FP op.
- `issue_ready_o`, out, 1: stage can accept an op.
- `issue_long_i`, in, 1: op is FPU_DIV or FPU_SQRT.
- `issue_to_int_i`, in, 1: result targets the integer regfile (FLOAT2INT, MOVE_FLOAT2INT).
- `issue_rd_i`, in, 5: destination register.
- `fpu_wdata_i`, in, 32: FPU result, selected upstream by `fp_op`.
- `fpu_status_i`, in, 8: DW status: [2] invalid, [3] tiny, [4] huge, [5] inexact, [7] div-by-zero.
- `flush_i`, in, 1: kill the in-flight op.
- `fp_we_o`, out, 1: FP regfile write enable.
- `fp_waddr_o`, out, 5: FP regfile write address.
- `fp_wdata_o`, out, 32: FP regfile write data.
- `int_we_o`, out, 1: integer regfile write enable.
- `int_waddr_o`, out, 5: integer regfile write address.
- `int_wdata_o`, out, 32: integer regfile write data.
- `csr_we_i`, in, 1: write `fflags`.
- `csr_wdata_i`, in, 5: new `fflags` value.
- `fflags_o`, out, 5: {NV, DZ, OF, UF, NX}.
- `busy_o`, out, 1: an op is in flight (state != IDLE).

## Operation
- FSM states: IDLE, WAIT, WB. Accept = `issue_valid_i & issue_ready_o & ~flush_i`.
- `issue_ready_o` = (state == IDLE or state == WB) and no long op is in WAIT. Back-to-back short ops sustain 1/cycle.
- Short op accepted:
  - Capture `fpu_wdata_i`, `fpu_status_i`, `issue_rd_i` and `issue_to_int_i` into the result registers.
  - Next state is WB.
- Long op accepted:
  - Latch rd and target.
  - Load a 4-bit counter with DIV_SQRT_LAT-1.
  - Next state is WAIT.
  - Upstream must hold operands and `fp_op` stable while `busy_o`.
- WAIT:
  - While counter != 0, decrement it.
  - When counter == 0, capture data and status and go to WB.
- WB:
  - Assert exactly one of `fp_we_o` / `int_we_o` for one cycle, with the latched address and data.
  - Next state is IDLE, or WB/WAIT if a new op is accepted in the same cycle.
- Write outputs are registered. Address and data hold their last value when the enable is low.
- Flag mapping, computed at capture: NV = s[2], DZ = s[7], OF = s[4], UF = s[3] & s[5], NX = s[5] | s[4].
- `fflags` accrual: in the WB cycle, `fflags` |= the captured mapped flags. MOVE ops must be issued with status 0; this block does not mask it.
- CSR write: `fflags` <= `csr_wdata_i`. If it coincides with a WB cycle, the result is `csr_wdata_i` | the WB flags.
- `flush_i`:
  - In WAIT or WB: no regfile write and no flag accrual that cycle. Next state is IDLE and the counter is cleared.
  - An issue presented in the same cycle is not accepted.
  - Flush in IDLE has no effect.

## Timing
- Reset values: `fp_we_o`=0, `int_we_o`=0, addresses 0, data 0, `fflags_o`=0, `busy_o`=0, `issue_ready_o`=1 (state IDLE, counter 0).
- Reset wins over every other input in the same cycle, including mid-WAIT. The in-flight op is dropped with no write.
- Short op: accepted at edge N, write enable high during cycle N+1.
- Long op: accepted at edge N, captured at edge N+DIV_SQRT_LAT, write enable high during cycle N+DIV_SQRT_LAT+1.
- `fflags_o` reflects the accrual in the cycle after the WB cycle (registered).

## Configuration
- `IBEX_FPU_FFLAGS_EN` defined: the `fflags` register, flag mapping and CSR write path are implemented as above.
- `IBEX_FPU_FFLAGS_EN` undefined: no flag register. `fflags_o` is tied to 0, and `csr_we_i`, `csr_wdata_i` and `fpu_status_i` are ignored. Writeback timing is unchanged.

## Test plan
- Reset, then a short FADD to rd=5 with data 0x3F800000 and status 0: `fp_we_o`=1 for exactly one cycle, one cycle after accept, with `fp_waddr_o`=5 and `fp_wdata_o`=0x3F800000. `fflags_o` stays 0.
- Three back-to-back short ops to rd=1, 2, 3: three consecutive write pulses, `issue_ready_o` stays 1 throughout.
- FDIV with DIV_SQRT_LAT=4 and status 0x80: `issue_ready_o`=0 for 4 cycles, write on cycle 5. `fflags_o` becomes 0b01000 (DZ).
- FLOAT2INT to rd=10 with data 0xFFFFFFFF and status 0x04: `int_we_o` pulses, `fp_we_o` stays 0. `fflags_o` becomes 0b10000.
- Long op with `flush_i` on the 2nd WAIT cycle: no write pulse and `fflags` unchanged. `issue_ready_o`=1 the next cycle.
- `csr_we_i` with 0b00001 in the same cycle as a WB carrying invalid status: `fflags_o`=0b10001. A later `csr_we_i` with 0 gives `fflags_o`=0.
